// File: rtl/self_write_frame_loader.sv
// Frame loader fed by a self-write word stream: SYNC_WORD opens a session, headers select a column, data words become frame writes.
// Optional SELF_WRITE_CHECKSUM_EN adds a per-frame XOR checkword state.
module self_write_frame_loader #(
    parameter logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1,
    parameter int          FRAME_WORDS = 20,
    parameter int          ADDR_W      = 8
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              SelfWriteStrobe,
    input  logic [31:0]       SelfWriteData,
    output logic [ADDR_W-1:0] FrameAddr,
    output logic [31:0]       FrameData,
    output logic              FrameStrobe,
    output logic              FrameDone,
    output logic              ComActive,
    output logic              Error
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);

    localparam logic [7:0] CMD_END   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
`ifdef SELF_WRITE_CHECKSUM_EN
        , CHECK  = 2'd3
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
`ifdef SELF_WRITE_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    // ComActive is registered alongside every state update so it always mirrors state != IDLE.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            word_cnt    <= '0;
            FrameAddr   <= '0;
            FrameData   <= '0;
            FrameStrobe <= 1'b0;
            FrameDone   <= 1'b0;
            ComActive   <= 1'b0;
            Error       <= 1'b0;
`ifdef SELF_WRITE_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            FrameStrobe <= 1'b0;
            FrameDone   <= 1'b0;
            if (SelfWriteStrobe) begin
                case (state)
                    IDLE: begin
                        if (SelfWriteData == SYNC_WORD) begin
                            state     <= HEADER;
                            ComActive <= 1'b1;
                            Error     <= 1'b0;
                        end
                    end
                    HEADER: begin
                        case (SelfWriteData[31:24])
                            CMD_WRITE: begin
                                FrameAddr <= SelfWriteData[ADDR_W-1:0];
                                word_cnt  <= '0;
`ifdef SELF_WRITE_CHECKSUM_EN
                                checksum  <= '0;
`endif
                                state     <= DATA;
                            end
                            CMD_END: begin
                                state     <= IDLE;
                                ComActive <= 1'b0;
                            end
                            default: begin
                                Error     <= 1'b1;
                                state     <= IDLE;
                                ComActive <= 1'b0;
                            end
                        endcase
                    end
                    DATA: begin
                        FrameData   <= SelfWriteData;
                        FrameStrobe <= 1'b1;
                        word_cnt    <= word_cnt + 1'b1;
`ifdef SELF_WRITE_CHECKSUM_EN
                        checksum    <= checksum ^ SelfWriteData;
`endif
                        // Counter stops at FRAME_WORDS because the next header reloads it.
                        if (word_cnt == LAST_IDX) begin
                            FrameDone <= 1'b1;
`ifdef SELF_WRITE_CHECKSUM_EN
                            state     <= CHECK;
`else
                            state     <= HEADER;
`endif
                        end
                    end
`ifdef SELF_WRITE_CHECKSUM_EN
                    CHECK: begin
                        if (SelfWriteData != checksum) begin
                            Error <= 1'b1;
                        end
                        state <= HEADER;
                    end
`endif
                    default: begin
                        state     <= IDLE;
                        ComActive <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_self_write_frame_loader.sv
// Directed bench for self_write_frame_loader: expected frame writes are queued on drive and checked by a negedge monitor.
// Compiling with SELF_WRITE_CHECKSUM_EN adds checkwords to every frame and the checksum scenarios.
module tb_self_write_frame_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam int          FW   = 20;

    logic        CLK;
    logic        resetn;
    logic        SelfWriteStrobe;
    logic [31:0] SelfWriteData;
    logic [7:0]  FrameAddr;
    logic [31:0] FrameData;
    logic        FrameStrobe;
    logic        FrameDone;
    logic        ComActive;
    logic        Error;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        done;
        int          due;
    } exp_t;

    exp_t sb[$];

    self_write_frame_loader #(
        .SYNC_WORD  (SYNC),
        .FRAME_WORDS(FW),
        .ADDR_W     (8)
    ) dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .SelfWriteStrobe(SelfWriteStrobe),
        .SelfWriteData  (SelfWriteData),
        .FrameAddr      (FrameAddr),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .FrameDone      (FrameDone),
        .ComActive      (ComActive),
        .Error          (Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; holds the word for exactly one sampling edge.
    task automatic applyStimulus(input logic [31:0] word, input int gap);
        SelfWriteStrobe = 1'b1;
        SelfWriteData   = word;
        @(negedge CLK);
        SelfWriteStrobe = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic expect_write(input logic [7:0] addr, input logic [31:0] data, input logic done);
        sb.push_back('{addr: addr, data: data, done: done, due: cyc + 1});
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [31:0] first, input int gap,
                              input logic [31:0] check_flip);
        logic [31:0] w;
        logic [31:0] xsum;
        xsum = '0;
        for (int i = 0; i < FW; i++) begin
            w = first + 32'(i);
            xsum = xsum ^ w;
            expect_write(addr, w, i == FW - 1);
            applyStimulus(w, gap);
        end
`ifdef SELF_WRITE_CHECKSUM_EN
        applyStimulus(xsum ^ check_flip, gap);
`else
        if (check_flip != 0) xsum = '0;
`endif
    endtask

    always @(negedge CLK) begin
        if (resetn === 1'b1) begin
            if (FrameStrobe === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_strobe", 32'(FrameStrobe), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("wr_addr", 32'(FrameAddr), 32'(e.addr));
                    checkOutput("wr_data", FrameData, e.data);
                    checkOutput("wr_done", 32'(FrameDone), 32'(e.done));
                    checkOutput("wr_latency", 32'(cyc), 32'(e.due));
                end
            end else begin
                checkOutput("done_without_strobe", 32'(FrameDone), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn          = 1'b0;
        SelfWriteStrobe = 1'b0;
        SelfWriteData   = '0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_addr",   32'(FrameAddr),   32'd0);
        checkOutput("rst_data",   FrameData,        32'd0);
        checkOutput("rst_strobe", 32'(FrameStrobe), 32'd0);
        checkOutput("rst_done",   32'(FrameDone),   32'd0);
        checkOutput("rst_active", 32'(ComActive),   32'd0);
        checkOutput("rst_error",  32'(Error),       32'd0);
        resetn = 1'b1;
        @(negedge CLK);

        // Junk before sync is ignored, then a spaced-out frame to column 3.
        applyStimulus(32'h1234_5678, 1);
        checkOutput("junk_active", 32'(ComActive), 32'd0);
        applyStimulus(SYNC, 1);
        checkOutput("sync_active", 32'(ComActive), 32'd1);
        applyStimulus(32'h0100_0003, 1);
        checkOutput("hdr_addr", 32'(FrameAddr), 32'd3);
        send_frame(8'd3, 32'd0, 1, 32'd0);
        checkOutput("f1_active",  32'(ComActive), 32'd1);
        checkOutput("f1_error",   32'(Error),     32'd0);
        checkOutput("f1_drained", 32'(sb.size()), 32'd0);

        // Same frame back-to-back, then end-of-session header.
        applyStimulus(32'h0100_0003, 0);
        send_frame(8'd3, 32'd0, 0, 32'd0);
        checkOutput("b2b_active", 32'(ComActive), 32'd1);
        applyStimulus(32'h0000_0000, 0);
        checkOutput("end_active", 32'(ComActive), 32'd0);
        @(negedge CLK);
        checkOutput("b2b_drained", 32'(sb.size()), 32'd0);

        // SYNC_WORD seen as a header is an illegal command.
        applyStimulus(SYNC, 1);
        applyStimulus(SYNC, 1);
        checkOutput("sync_hdr_error",  32'(Error),     32'd1);
        checkOutput("sync_hdr_active", 32'(ComActive), 32'd0);
        applyStimulus(SYNC, 1);
        checkOutput("resync_error",  32'(Error),     32'd0);
        checkOutput("resync_active", 32'(ComActive), 32'd1);

        // Bad command, sticky error, cleared by the next sync.
        applyStimulus(32'h7F00_0001, 1);
        checkOutput("badcmd_error",  32'(Error),     32'd1);
        checkOutput("badcmd_active", 32'(ComActive), 32'd0);
        applyStimulus(32'h0000_0055, 1);
        checkOutput("error_sticky", 32'(Error), 32'd1);
        applyStimulus(SYNC, 1);
        checkOutput("sync_clears_error", 32'(Error), 32'd0);

        // Frame whose data contains SYNC_WORD.
        applyStimulus(32'h0100_002A, 1);
        send_frame(8'h2A, SYNC - 32'd5, 0, 32'd0);
        applyStimulus(32'h0000_0000, 1);
        checkOutput("syncdata_end_active", 32'(ComActive), 32'd0);

        // Reset mid-frame after the seventh word.
        applyStimulus(SYNC, 1);
        applyStimulus(32'h0100_0005, 1);
        for (int i = 0; i < 7; i++) begin
            expect_write(8'd5, 32'd100 + 32'(i), 1'b0);
            applyStimulus(32'd100 + 32'(i), 0);
        end
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_rst_addr",   32'(FrameAddr),   32'd0);
        checkOutput("async_rst_data",   FrameData,        32'd0);
        checkOutput("async_rst_strobe", 32'(FrameStrobe), 32'd0);
        checkOutput("async_rst_done",   32'(FrameDone),   32'd0);
        checkOutput("async_rst_active", 32'(ComActive),   32'd0);
        checkOutput("async_rst_error",  32'(Error),       32'd0);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < FW; i++) applyStimulus(32'(i), 0);
        @(negedge CLK);
        checkOutput("post_rst_active", 32'(ComActive), 32'd0);
        checkOutput("post_rst_addr",   32'(FrameAddr), 32'd0);

`ifdef SELF_WRITE_CHECKSUM_EN
        // Words 1..20 XOR to 0x14: good checkword, bad checkword, then a further header.
        applyStimulus(SYNC, 1);
        applyStimulus(32'h0100_0007, 1);
        send_frame(8'd7, 32'd1, 1, 32'd0);
        checkOutput("chk_good_error", 32'(Error), 32'd0);
        applyStimulus(32'h0100_0007, 1);
        send_frame(8'd7, 32'd1, 1, 32'h0000_0014);
        checkOutput("chk_bad_error", 32'(Error), 32'd1);
        applyStimulus(32'h0100_0004, 1);
        checkOutput("chk_next_hdr_addr", 32'(FrameAddr), 32'd4);
        send_frame(8'd4, 32'd1, 1, 32'd0);
        checkOutput("chk_next_active", 32'(ComActive), 32'd1);
        checkOutput("chk_error_kept",  32'(Error),     32'd1);
`endif

        repeat (3) @(negedge CLK);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
